// File: rtl/seq_mul_shift_add.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// Borrows an external combinational adder through add_a/add_b/add_sum instead of owning one.
module seq_mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [5:0]       cnt_r;
    logic             run_last_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; RUN ends once no multiplier bits remain or all bits are consumed
    always_comb begin
        next_state_s = state_r;
        run_last_s   = (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}) ||
                       (cnt_r == 6'(WIDTH-1));
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (run_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture in IDLE, one shift-add step per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        acc_r    <= {WIDTH{1'b0}};
                        mcand_r  <= in_a;
                        mplier_r <= in_b;
                        cnt_r    <= 6'd0;
                    end
                end
                RUN: begin
                    acc_r    <= add_sum;
                    mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + 6'd1;
                end
                default: begin
                    acc_r    <= acc_r;
                    mcand_r  <= mcand_r;
                    mplier_r <= mplier_r;
                    cnt_r    <= cnt_r;
                end
            endcase
        end
    end

    // Output decode; the adder sees zeros whenever it is not in use
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = {WIDTH{1'b0}};
        add_b     = {WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                add_a = acc_r;
                if (mplier_r[0]) begin
                    add_b = mcand_r;
                end else begin
                    add_b = {WIDTH{1'b0}};
                end
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_product = acc_r;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Self-checking bench for seq_mul_shift_add with an arithmetic reference model
// and a behavioural stand-in for the external adder.
module tb_seq_mul_shift_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_product;

    int checks   = 0;
    int failures = 0;

    seq_mul_shift_add #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product)
    );

    assign add_sum = add_a + add_b;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of shift-add steps: position of the top set bit plus one, at least one
    function automatic int ref_steps(input logic [31:0] b);
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    // Accumulator value before step k: a times the low k bits of b, mod 2^32
    function automatic logic [31:0] ref_partial(input logic [31:0] a, input logic [31:0] b,
                                                input int k);
        logic [31:0] m;
        logic [31:0] p;
        m = (k >= 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
        p = a * (b & m);
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_product"}, out_product, 32'd0);
        check({tag, "_add_a"}, add_a, 32'd0);
        check({tag, "_add_b"}, add_b, 32'd0);
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_add_a", add_a, 32'd0);
        check("idle_add_b", add_b, 32'd0);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic finish_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        int          k;
        logic [31:0] prod;
        logic [31:0] exp_b;
        prod = a * b;
        k = 0;
        while (!out_valid && k < 40) begin
            check("run_in_ready", {31'd0, in_ready}, 32'd0);
            if (k < 32) begin
                exp_b = b[k] ? (a << k) : 32'd0;
                check("run_add_a", add_a, ref_partial(a, b, k));
                check("run_add_b", add_b, exp_b);
            end
            tick();
            k++;
        end
        check("run_cycles", k, ref_steps(b));
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
        check("done_product", out_product, prod);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        check("done_add_a", add_a, 32'd0);
        check("done_add_b", add_b, 32'd0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = h[0];
            in_a      = $urandom;
            in_b      = $urandom;
            tick();
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_product", out_product, prod);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_out_valid", {31'd0, out_valid}, 32'd0);
        check("after_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        accept(32'd3, 32'd5);
        finish_op(32'd3, 32'd5, 0);

        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        accept(32'h1234_5678, 32'd0);
        finish_op(32'h1234_5678, 32'd0, 0);

        accept(32'h0001_0000, 32'h0001_0000);
        finish_op(32'h0001_0000, 32'h0001_0000, 0);

        accept(32'hDEAD_BEEF, 32'h0000_0013);
        finish_op(32'hDEAD_BEEF, 32'h0000_0013, 10);

        // Reset in the middle of RUN discards the operation
        accept(32'd7, 32'd9);
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_run_reset");
        tick();
        rst = 1'b0;
        tick();
        accept(32'd6, 32'd7);
        finish_op(32'd6, 32'd7, 0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            accept(ra, rb);
            finish_op(ra, rb, i % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
